// File: rtl/instr_mem_loadable_pkg.sv
// Shared types for the loadable instruction memory.
// Contents:
//   imem_state_t  - load/serve state of the memory
//   IMEM_NOP_WORD - default word returned on a faulting fetch (addi x0,x0,0)
//   imem_rsp_t    - fetch response bundle for the default 32-bit word width
package instr_mem_pkg;

  typedef enum logic [1:0] {
    IMEM_EMPTY,
    IMEM_LOAD,
    IMEM_READY
  } imem_state_t;

  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic        fault;
    logic [31:0] instr;
  } imem_rsp_t;

endpackage

// File: rtl/instr_mem_loadable_array.sv
// Synchronous RAM holding program words: one write port, one registered
// read port. Kept on its own so it can later be mapped onto block RAM.
// Ports:
//   clk   - clock, rising edge
//   we    - write enable, writes wdata to mem[waddr]
//   waddr - write word index
//   wdata - write word
//   re    - read enable; rdata holds its value when low
//   raddr - read word index
//   rdata - registered read data
module imem_array #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction memory with pipelined fetch port.
// A program is streamed in through the load port (load_start, load_valid,
// load_data, load_done); the fetch port then returns one word per request
// exactly LAT cycles later, or NOP_WORD with fetch_fault set when the
// memory is not READY, the address is misaligned, or it lies past the
// loaded program.
// Ports:
//   clk, rst                  - clock and synchronous active-high reset
//   load_start/valid/data/done - program load stream
//   load_err                  - sticky: a word was dropped on a full array
//   loaded_count              - words written by the current load
//   busy                      - memory not READY; fetch must stall
//   fetch_req, fetch_addr     - fetch request, byte address
//   fetch_valid/instr/fault   - fetch response
module instr_mem_loadable
  import instr_mem_pkg::*;
#(
  parameter int               DEPTH    = 1024,
  parameter int               ADDR_W   = 32,
  parameter int               DATA_W   = 32,
  parameter int               LAT      = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = IMEM_NOP_WORD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [DATA_W-1:0]          load_data,
  input  logic                       load_done,
  output logic                       load_err,
  output logic [$clog2(DEPTH+1)-1:0] loaded_count,
  output logic                       busy,
  input  logic                       fetch_req,
  input  logic [ADDR_W-1:0]          fetch_addr,
  output logic                       fetch_valid,
  output logic [DATA_W-1:0]          fetch_instr,
  output logic                       fetch_fault
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CMP_W = ADDR_W - 2 + CNT_W;

  imem_state_t       state;
  logic [CNT_W-1:0]  load_ptr;
  logic              full;
  logic              wr_en;
  logic              req_fault;
  logic [DATA_W-1:0] rd_data;
  logic              v1;
  logic              f1;
  logic              nop1;
  logic [DATA_W-1:0] instr1;

  assign full         = (load_ptr == CNT_W'(DEPTH));
  assign loaded_count = load_ptr;

  // load_start wins over any word offered in the same cycle.
  assign wr_en = (state == IMEM_LOAD) && !load_start && load_valid && !full;

  // Compare the full word address (upper bits included) so addresses past
  // the array never alias back onto low words.
  assign req_fault = (state != IMEM_READY) || (fetch_addr[1:0] != 2'b00) ||
                     (CMP_W'(fetch_addr[ADDR_W-1:2]) >= CMP_W'(load_ptr));

  imem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (wr_en),
    .waddr (load_ptr[IDX_W-1:0]),
    .wdata (load_data),
    .re    (fetch_req),
    .raddr (fetch_addr[IDX_W+1:2]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IMEM_EMPTY;
      load_ptr <= '0;
      load_err <= 1'b0;
      busy     <= 1'b1;
    end else if (load_start) begin
      state    <= IMEM_LOAD;
      load_ptr <= '0;
      load_err <= 1'b0;
      busy     <= 1'b1;
    end else if (state == IMEM_LOAD) begin
      if (load_valid) begin
        if (full) load_err <= 1'b1;
        else      load_ptr <= load_ptr + 1'b1;
      end
      if (load_done) begin
        state <= IMEM_READY;
        busy  <= 1'b0;
      end
    end
  end

  // First response stage. The RAM holds its read data between requests, and
  // nop1 (reset high) forces NOP_WORD out of reset or after a faulting fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      f1   <= 1'b0;
      nop1 <= 1'b1;
    end else begin
      v1 <= fetch_req;
      if (fetch_req) begin
        f1   <= req_fault;
        nop1 <= req_fault;
      end
    end
  end

  assign instr1 = nop1 ? NOP_WORD : rd_data;

  generate
    if (LAT == 1) begin : g_lat1
      assign fetch_valid = v1;
      assign fetch_fault = f1;
      assign fetch_instr = instr1;
    end else if (LAT == 2) begin : g_lat2
      logic              v2;
      logic              f2;
      logic [DATA_W-1:0] i2;
      always_ff @(posedge clk) begin
        if (rst) begin
          v2 <= 1'b0;
          f2 <= 1'b0;
          i2 <= NOP_WORD;
        end else begin
          v2 <= v1;
          if (v1) begin
            f2 <= f1;
            i2 <= instr1;
          end
        end
      end
      assign fetch_valid = v2;
      assign fetch_fault = f2;
      assign fetch_instr = i2;
    end else begin : g_bad_lat
      $error("instr_mem_loadable: LAT must be 1 or 2");
    end
  endgenerate

endmodule

// File: tb/tb_instr_mem_loadable.sv
module tb_instr_mem_loadable;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, load_start, load_valid, load_done, fetch_req;
  logic [31:0] load_data, fetch_addr;

  // index 0: DEPTH=1024 LAT=1, index 1: DEPTH=4 LAT=2
  logic        lerr [2];
  logic        bsy  [2];
  logic        fv   [2];
  logic        ff   [2];
  logic [31:0] fi   [2];
  logic [10:0] lc0;
  logic [2:0]  lc1;

  always #5 clk = ~clk;

  instr_mem_loadable #(.DEPTH(1024), .LAT(1)) dut_a (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_done(load_done), .load_err(lerr[0]),
    .loaded_count(lc0), .busy(bsy[0]), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .fetch_valid(fv[0]), .fetch_instr(fi[0]),
    .fetch_fault(ff[0]));

  instr_mem_loadable #(.DEPTH(4), .LAT(2)) dut_b (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_done(load_done), .load_err(lerr[1]),
    .loaded_count(lc1), .busy(bsy[1]), .fetch_req(fetch_req),
    .fetch_addr(fetch_addr), .fetch_valid(fv[1]), .fetch_instr(fi[1]),
    .fetch_fault(ff[1]));

  // Reference model: state 0=empty 1=loading 2=ready
  int          depth [2] = '{1024, 4};
  int          lat   [2] = '{1, 2};
  int          m_state [2];
  int          m_cnt   [2];
  bit          m_err   [2];
  logic [31:0] m_mem   [2][1024];
  bit          p_v [2];
  bit          p_f [2];
  logic [31:0] p_i [2];
  bit          o_v [2];
  bit          o_f [2];
  logic [31:0] o_i [2];

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_state[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
        p_v[k] = 0; o_v[k] = 0; o_f[k] = 0; o_i[k] = NOP;
      end else begin
        bit          rf;
        logic [31:0] ri;
        rf = (m_state[k] != 2) || (fetch_addr[1:0] != 0) ||
             ((fetch_addr >> 2) >= 32'(m_cnt[k]));
        ri = rf ? NOP : m_mem[k][fetch_addr >> 2];
        if (lat[k] == 1) begin
          o_v[k] = fetch_req;
          if (fetch_req) begin o_f[k] = rf; o_i[k] = ri; end
        end else begin
          o_v[k] = p_v[k];
          if (p_v[k]) begin o_f[k] = p_f[k]; o_i[k] = p_i[k]; end
          p_v[k] = fetch_req;
          if (fetch_req) begin p_f[k] = rf; p_i[k] = ri; end
        end
        if (load_start) begin
          m_state[k] = 1; m_cnt[k] = 0; m_err[k] = 0;
        end else if (m_state[k] == 1) begin
          if (load_valid) begin
            if (m_cnt[k] < depth[k]) begin
              m_mem[k][m_cnt[k]] = load_data;
              m_cnt[k]++;
            end else m_err[k] = 1;
          end
          if (load_done) m_state[k] = 2;
        end
      end
    end
  endtask

  task automatic check_all(string where);
    for (int k = 0; k < 2; k++) begin
      string p;
      p = $sformatf("%s/d%0d", where, k);
      chk({p, "_busy"}, 32'(bsy[k]), 32'(m_state[k] != 2));
      chk({p, "_err"}, 32'(lerr[k]), 32'(m_err[k]));
      chk({p, "_count"}, (k == 0) ? 32'(lc0) : 32'(lc1), 32'(m_cnt[k]));
      chk({p, "_valid"}, 32'(fv[k]), 32'(o_v[k]));
      chk({p, "_fault"}, 32'(ff[k]), 32'(o_f[k]));
      chk({p, "_instr"}, fi[k], o_i[k]);
    end
  endtask

  task automatic cyc(string where, bit r, bit ls, bit lv, logic [31:0] d,
                     bit ld, bit rq, logic [31:0] a);
    rst = r; load_start = ls; load_valid = lv; load_data = d;
    load_done = ld; fetch_req = rq; fetch_addr = a;
    @(posedge clk);
    model_edge();
    #1;
    check_all(where);
  endtask

  task automatic idle(string where);
    cyc(where, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc("reset", 1, 0, 0, 0, 0, 0, 0);
    cyc("reset", 1, 0, 0, 0, 0, 0, 0);
    // basic load of two words then a fetch
    cyc("ls", 0, 1, 0, 0, 0, 0, 0);
    cyc("ld0", 0, 0, 1, 32'h0062E233, 0, 0, 0);
    cyc("ld1", 0, 0, 1, 32'h00B62423, 0, 0, 0);
    cyc("done", 0, 0, 0, 0, 1, 0, 0);
    cyc("f0", 0, 0, 0, 0, 0, 1, 32'h0);
    // back-to-back fetches
    cyc("b2b", 0, 0, 0, 0, 0, 1, 32'h4);
    cyc("b2b", 0, 0, 0, 0, 0, 1, 32'h0);
    cyc("b2b", 0, 0, 0, 0, 0, 1, 32'h4);
    idle("b2b"); idle("b2b");
    // fault cases
    cyc("past_end", 0, 0, 0, 0, 0, 1, 32'h8);
    cyc("misalign", 0, 0, 0, 0, 0, 1, 32'h2);
    cyc("alias", 0, 0, 0, 0, 0, 1, 32'h1000);
    idle("flt"); idle("flt");
    // overfill the 4-deep array
    cyc("ls5", 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc("w5", 0, 0, 1, $urandom, 0, 0, 0);
    cyc("done5", 0, 0, 0, 0, 1, 0, 0);
    cyc("f_c", 0, 0, 0, 0, 0, 1, 32'hC);
    cyc("f_10", 0, 0, 0, 0, 0, 1, 32'h10);
    idle("w5"); idle("w5");
    // fetch while loading, then reset mid-load with fetches in flight
    cyc("lsm", 0, 1, 0, 0, 0, 1, 32'h0);
    for (int i = 0; i < 3; i++) cyc("wm", 0, 0, 1, $urandom, 0, 1, 32'h0);
    cyc("rst_mid", 1, 0, 0, 0, 0, 1, 32'h0);
    cyc("empty_f", 0, 0, 0, 0, 0, 1, 32'h0);
    idle("empty"); idle("empty");
    // same-cycle valid+done, then reload with fetch in flight
    cyc("ls6", 0, 1, 0, 0, 0, 0, 0);
    cyc("w6", 0, 0, 1, 32'hAAAA_0001, 0, 0, 0);
    cyc("w6done", 0, 0, 1, 32'hAAAA_0002, 1, 0, 0);
    cyc("f6", 0, 0, 0, 0, 0, 1, 32'h4);
    cyc("f_old", 0, 0, 0, 0, 0, 1, 32'h0);
    cyc("reload", 0, 1, 0, 0, 0, 0, 0);
    cyc("f_new", 0, 0, 1, 32'hBBBB_0001, 0, 1, 32'h0);
    cyc("done7", 0, 0, 0, 0, 1, 0, 0);
    idle("r7"); idle("r7");
    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      bit          r, ls, lv, ld, rq;
      logic [31:0] a;
      int          sel;
      r  = ($urandom_range(0, 199) == 0);
      ls = ($urandom_range(0, 39) == 0);
      lv = ($urandom_range(0, 2) == 0);
      ld = ($urandom_range(0, 11) == 0);
      rq = ($urandom_range(0, 9) < 6);
      sel = $urandom_range(0, 9);
      if (sel < 7)      a = 32'($urandom_range(0, 7)) << 2;
      else if (sel < 9) a = 32'($urandom_range(0, 31));
      else              a = $urandom;
      cyc("rand", r, ls, lv, $urandom, ld, rq, a);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
- Parametrised, clocked successor to the combinational instruction memory.
- Holds program words in a synchronous-read array and is filled at run time through a streaming load port, so programs are no longer fixed by initial blocks.
- Serves the fetch stage through a pipelined request/valid handshake with 1 or 2 cycle latency.
- Flags misaligned or unloaded fetch addresses with a NOP and a fault bit.

Parameters:
- DEPTH, 1024, number of DATA_W-bit words.
- ADDR_W, 32, byte-address width of fetch_addr.
- DATA_W, 32, instruction word width.
- LAT, 1, fetch latency in cycles; legal values 1 or 2 only; other values are an elaboration error.
- NOP_WORD, 32'h00000013, word returned on a faulting fetch (RV32I addi x0,x0,0).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  begin or restart a program load; load pointer returns to 0.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  DATA_W  word written to mem[load_ptr].
- load_done  in  1  end of program; enter READY.
- load_err  out  1  sticky; a load word was dropped because the array was full.
- loaded_count  out  $clog2(DEPTH+1)  number of words written in the current load.
- busy  out  1  high in EMPTY and LOAD; the CPU must stall fetch.
- fetch_req  in  1  fetch request, one accepted per cycle.
- fetch_addr  in  ADDR_W  byte address of the fetch.
- fetch_valid  out  1  response valid; asserted exactly LAT cycles after a request.
- fetch_instr  out  DATA_W  fetched instruction.
- fetch_fault  out  1  qualifies fetch_valid; the response is a fault.

Behaviour:
- Reset values:
  - state=EMPTY, load_ptr=0, loaded_count=0, load_err=0, busy=1.
  - fetch_valid=0, fetch_instr=NOP_WORD, fetch_fault=0.
  - Latency pipeline flushed.
  - Array contents are not cleared.
- States:
  - EMPTY: load_start -> LOAD.
  - LOAD:
    - load_valid writes mem[load_ptr] and increments load_ptr and loaded_count.
    - load_done -> READY. A load_valid in the same cycle as load_done is written first.
    - load_start restarts the load: ptr=0, count=0, load_err cleared.
  - READY:
    - load_start -> LOAD: ptr=0, count=0, load_err cleared.
    - load_valid and load_done are ignored.
  - load_start has priority over load_done in the same cycle.
- Full array: load_valid with load_ptr==DEPTH drops the word and sets load_err; loaded_count saturates at DEPTH.
- Fetch:
  - A request is sampled every cycle fetch_req=1; the pipeline is fully pipelined with no backpressure.
  - Index = fetch_addr[$clog2(DEPTH)+1:2].
  - A request faults if any of these hold:
    - state != READY;
    - fetch_addr[1:0] != 0;
    - fetch_addr >> 2 >= loaded_count, so upper address bits are included and there is no wrap-around aliasing.
  - Faulting response: fetch_instr=NOP_WORD, fetch_fault=1.
  - Non-faulting response: fetch_instr=mem[index], fetch_fault=0.
- Latency:
  - LAT=1: response registered on the edge after the request cycle.
  - LAT=2: an additional output register stage.
  - The array is read in the request cycle, so later loads never alter an in-flight response.
- No request: fetch_valid=0; fetch_instr and fetch_fault hold their last values.
- Mid-operation events:
  - Entering LOAD from READY: in-flight fetches complete normally; new requests fault.
  - rst mid-load or mid-fetch: all reset values apply on the next edge, and in-flight responses are discarded (fetch_valid=0).

Decomposition:
- Package instr_mem_pkg:
  - state enum imem_state_t {IMEM_EMPTY, IMEM_LOAD, IMEM_READY};
  - localparam NOP_WORD default;
  - fetch response struct {valid, fault, instr}.
- One sub-module, imem_array: single-port-write/single-port-read synchronous RAM (DEPTH x DATA_W, write enable, registered read). Keeping the RAM separate allows later mapping to BRAM.
- The state machine, counters and latency pipeline stay in the top module.

Test Plan:
1. rst; load_start; load 0x0062E233 then 0x00B62423; load_done -> loaded_count=2, busy=0. Fetch addr 0x0 -> next cycle fetch_valid=1, fetch_instr=0x0062E233, fault=0.
2. READY, back-to-back fetches 0x4, 0x0, 0x4 with LAT=2 -> valid in cycles +2, +3, +4 with 0x00B62423, 0x0062E233, 0x00B62423.
3. Fault cases:
   - Fetch 0x8 with count=2 -> fault=1, instr=0x00000013.
   - Fetch 0x2 -> fault=1.
   - Fetch 0x1000 with DEPTH=1024 -> fault=1, no aliasing to word 0.
4. DEPTH=4, load 5 words -> load_err=1, loaded_count=4. Fetch 0xC returns the 4th word; the 5th word is absent.
5. Fetch during EMPTY or LOAD -> fault=1. rst asserted after 3 load words -> loaded_count=0, state EMPTY, load_err=0, fetch_valid=0 next cycle.
6. Same-cycle load_valid+load_done -> word written, READY next cycle. In READY, load_start with a fetch in flight -> in-flight response returns the old data; fetch issued after load_start faults.
